// File: rtl/keypad_scan_debounce.sv
// 4x4 matrix keypad scanner with press/release debouncing and a valid/ready
// key delivery port. One key is delivered per physical press.
module keypad_scan_debounce #(
   parameter int SCAN_DIV  = 10,
   parameter int DEB_COUNT = 20
) (
   input  logic       clk,
   input  logic       resetn,
   input  logic [3:0] row_n,
   output logic [3:0] col_n,
   output logic [3:0] key_code,
   output logic       key_valid,
   input  logic       key_ready,
   output logic       key_held
);

   localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int CW = $clog2(DEB_COUNT + 1);
   localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
   localparam logic [CW-1:0] DEB_TARGET = CW'(DEB_COUNT);
   localparam logic [CW-1:0] DEB_LAST   = CW'(DEB_COUNT - 1);

   typedef enum logic [1:0] {
      ST_SCAN     = 2'd0,
      ST_DEBOUNCE = 2'd1,
      ST_PRESSED  = 2'd2,
      ST_RELEASE  = 2'd3
   } state_t;

   function automatic logic one_low(input logic [3:0] rows);
      case (rows)
         4'b1110, 4'b1101, 4'b1011, 4'b0111: one_low = 1'b1;
         default:                            one_low = 1'b0;
      endcase
   endfunction

   function automatic logic [1:0] low_index(input logic [3:0] rows);
      case (rows)
         4'b1110: low_index = 2'd0;
         4'b1101: low_index = 2'd1;
         4'b1011: low_index = 2'd2;
         4'b0111: low_index = 2'd3;
         default: low_index = 2'd0;
      endcase
   endfunction

   state_t          r_state, w_nxt_state;
   logic [3:0]      r_sync1, r_rows_s;
   logic [DW-1:0]   r_dwell;
   logic [1:0]      r_col, w_nxt_col;
   logic [3:0]      r_col_n, w_nxt_col_n;
   logic [1:0]      r_row_idx, w_nxt_row_idx;
   logic [3:0]      r_pattern, w_nxt_pattern;
   logic [CW-1:0]   r_deb_cnt, w_nxt_deb_cnt;
   logic [3:0]      r_key_code, w_nxt_key_code;
   logic            r_key_valid, w_nxt_key_valid;
   logic            r_key_held, w_nxt_key_held;
   logic            w_sample;

   assign w_sample = (r_dwell == DWELL_LAST);

   // Row synchronizer and the free-running dwell/sample counter.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_sync1  <= 4'b1111;
         r_rows_s <= 4'b1111;
         r_dwell  <= {DW{1'b0}};
      end else begin
         r_sync1  <= row_n;
         r_rows_s <= r_sync1;
         r_dwell  <= w_sample ? {DW{1'b0}} : r_dwell + DW'(1'b1);
      end
   end

   // State register.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_state <= ST_SCAN;
      end else begin
         r_state <= w_nxt_state;
      end
   end

   // Next-state and next-output logic; column only moves on sample points.
   always_comb begin
      w_nxt_state     = r_state;
      w_nxt_col       = r_col;
      w_nxt_row_idx   = r_row_idx;
      w_nxt_pattern   = r_pattern;
      w_nxt_deb_cnt   = r_deb_cnt;
      w_nxt_key_code  = r_key_code;
      w_nxt_key_valid = r_key_valid;
      w_nxt_key_held  = r_key_held;
      case (r_state)
         ST_SCAN: begin
            if (w_sample && one_low(r_rows_s)) begin
               w_nxt_row_idx = low_index(r_rows_s);
               w_nxt_pattern = r_rows_s;
               w_nxt_deb_cnt = {CW{1'b0}};
               w_nxt_state   = ST_DEBOUNCE;
            end else if (w_sample) begin
               w_nxt_col = r_col + 2'd1;
            end else begin
               w_nxt_state = ST_SCAN;
            end
         end
         ST_DEBOUNCE: begin
            if (w_sample && (r_rows_s == r_pattern)) begin
               if (r_deb_cnt >= DEB_LAST) begin
                  w_nxt_deb_cnt   = DEB_TARGET;
                  w_nxt_key_code  = {r_row_idx, r_col};
                  w_nxt_key_valid = 1'b1;
                  w_nxt_key_held  = 1'b1;
                  w_nxt_state     = ST_PRESSED;
               end else begin
                  w_nxt_deb_cnt = r_deb_cnt + CW'(1'b1);
               end
            end else if (w_sample) begin
               w_nxt_deb_cnt = {CW{1'b0}};
               w_nxt_col     = r_col + 2'd1;
               w_nxt_state   = ST_SCAN;
            end else begin
               w_nxt_state = ST_DEBOUNCE;
            end
         end
         ST_PRESSED: begin
            if (r_key_valid && key_ready) begin
               w_nxt_key_valid = 1'b0;
               w_nxt_deb_cnt   = {CW{1'b0}};
               w_nxt_state     = ST_RELEASE;
            end else begin
               w_nxt_state = ST_PRESSED;
            end
         end
         ST_RELEASE: begin
            if (w_sample && (r_rows_s == 4'b1111)) begin
               if (r_deb_cnt >= DEB_LAST) begin
                  w_nxt_deb_cnt  = DEB_TARGET;
                  w_nxt_key_held = 1'b0;
                  w_nxt_col      = r_col + 2'd1;
                  w_nxt_state    = ST_SCAN;
               end else begin
                  w_nxt_deb_cnt = r_deb_cnt + CW'(1'b1);
               end
            end else if (w_sample) begin
               w_nxt_deb_cnt = {CW{1'b0}};
            end else begin
               w_nxt_state = ST_RELEASE;
            end
         end
         default: begin
            w_nxt_state = ST_SCAN;
         end
      endcase
      w_nxt_col_n = ~(4'b0001 << w_nxt_col);
   end

   // Datapath and output registers.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_col       <= 2'd0;
         r_col_n     <= 4'b1110;
         r_row_idx   <= 2'd0;
         r_pattern   <= 4'b1111;
         r_deb_cnt   <= {CW{1'b0}};
         r_key_code  <= 4'd0;
         r_key_valid <= 1'b0;
         r_key_held  <= 1'b0;
      end else begin
         r_col       <= w_nxt_col;
         r_col_n     <= w_nxt_col_n;
         r_row_idx   <= w_nxt_row_idx;
         r_pattern   <= w_nxt_pattern;
         r_deb_cnt   <= w_nxt_deb_cnt;
         r_key_code  <= w_nxt_key_code;
         r_key_valid <= w_nxt_key_valid;
         r_key_held  <= w_nxt_key_held;
      end
   end

   assign col_n     = r_col_n;
   assign key_code  = r_key_code;
   assign key_valid = r_key_valid;
   assign key_held  = r_key_held;

endmodule

// File: tb/tb_keypad_scan_debounce.sv
// Bench for keypad_scan_debounce: emulated 4x4 key matrix, random presses with
// bounce, and a scoreboard of key codes expected on the valid/ready port.
module tb_keypad_scan_debounce;

   localparam int SCAN_DIV  = 4;
   localparam int DEB_COUNT = 3;

   logic       clk = 1'b0;
   logic       resetn;
   logic [3:0] row_n;
   logic [3:0] col_n;
   logic [3:0] key_code;
   logic       key_valid;
   logic       key_ready;
   logic       key_held;

   logic [15:0] keys;
   logic [3:0]  exp_q[$];
   int          checks   = 0;
   int          failures = 0;
   int          ready_mode;

   keypad_scan_debounce #(.SCAN_DIV(SCAN_DIV), .DEB_COUNT(DEB_COUNT)) dut (
      .clk       (clk),
      .resetn    (resetn),
      .row_n     (row_n),
      .col_n     (col_n),
      .key_code  (key_code),
      .key_valid (key_valid),
      .key_ready (key_ready),
      .key_held  (key_held)
   );

   always #5 clk = ~clk;

   // Key matrix: a closed key pulls its row low while its column is driven low.
   always_comb begin
      row_n = 4'b1111;
      for (int r = 0; r < 4; r++) begin
         row_n[r] = ~|(keys[r*4 +: 4] & ~col_n);
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic check_range(input string name, input int act, input int lo, input int hi);
      checks++;
      if (act < lo || act > hi) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
      end
   endtask

   task automatic cycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic wait_valid(input int budget, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget && !ok; i++) begin
         @(negedge clk);
         if (key_valid === 1'b1) ok = 1'b1;
      end
   endtask

   task automatic wait_held_low(input int budget, output bit ok, output int n);
      ok = 1'b0;
      n  = 0;
      for (int i = 0; i < budget && !ok; i++) begin
         @(negedge clk);
         if (key_held === 1'b0) begin
            ok = 1'b1;
            n  = i;
         end
      end
   endtask

   task automatic press_release(input int k, input bit bounce);
      bit ok;
      int n;
      exp_q.push_back(4'(k));
      if (bounce) begin
         repeat ($urandom_range(1, 2)) begin
            keys[k] = 1'b1;
            cycles($urandom_range(2, 6));
            keys[k] = 1'b0;
            cycles($urandom_range(2, 6));
         end
      end
      keys[k] = 1'b1;
      cycles(70);
      keys[k] = 1'b0;
      if (bounce) begin
         cycles($urandom_range(1, 3));
         keys[k] = 1'b1;
         cycles($urandom_range(1, 3));
         keys[k] = 1'b0;
      end
      wait_held_low(300, ok, n);
      check("release_done", ok, 1);
      check("pending_after_release", exp_q.size(), 0);
      cycles(20);
   endtask

   task automatic multi_key();
      int c  = $urandom_range(0, 3);
      int r1 = $urandom_range(0, 3);
      int r2 = (r1 + $urandom_range(1, 3)) % 4;
      keys[r1*4 + c] = 1'b1;
      keys[r2*4 + c] = 1'b1;
      cycles(70);
      check("multi_held", key_held, 0);
      check("multi_valid", key_valid, 0);
      keys = 16'h0000;
      cycles(20);
   endtask

   // Consumer ready: off, on, or random depending on the scenario.
   initial begin
      key_ready = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         case (ready_mode)
            0:       key_ready = 1'b0;
            1:       key_ready = 1'b1;
            default: key_ready = ($urandom_range(0, 3) != 0);
         endcase
      end
   end

   // Monitor: every transfer pops the scoreboard; invariants checked each cycle.
   always @(negedge clk) begin
      if (resetn === 1'b1) begin
         check("col_one_low", $countones(~col_n), 1);
         if (key_valid === 1'b1) check("held_with_valid", key_held, 1);
         if (key_valid === 1'b1 && key_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_xfer: code %0h delivered, none pending", key_code);
            end else begin
               check("xfer_code", key_code, exp_q.pop_front());
            end
         end
      end
   end

   initial begin
      #1000000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      bit          ok;
      int          n;
      logic [3:0]  one;
      logic [3:0]  exp_col;
      one        = 4'b0001;
      keys       = 16'h0000;
      ready_mode = 0;
      resetn     = 1'b0;
      repeat (3) @(posedge clk);
      #2;
      check("rst_col_n", col_n, 4'b1110);
      check("rst_code", key_code, 0);
      check("rst_valid", key_valid, 0);
      check("rst_held", key_held, 0);
      resetn = 1'b1;

      // Idle scanning: column advances every SCAN_DIV cycles
      for (int k = 1; k <= 32; k++) begin
         @(posedge clk);
         @(negedge clk);
         exp_col = ~(one << ((k / SCAN_DIV) % 4));
         check("idle_col", col_n, exp_col);
         check("idle_valid", key_valid, 0);
      end

      // Clean press of key 9 with consumer always ready
      ready_mode = 1;
      exp_q.push_back(4'd9);
      keys[9] = 1'b1;
      wait_valid(100, ok);
      check("k9_valid_seen", ok, 1);
      check("k9_code", key_code, 9);
      @(negedge clk);
      check("k9_valid_one_cycle", key_valid, 0);
      check("k9_held", key_held, 1);
      cycles(20);
      check("k9_held_while_pressed", key_held, 1);
      keys[9] = 1'b0;
      wait_held_low(100, ok, n);
      check("k9_release", ok, 1);
      check_range("k9_release_latency", n, 10, 13);
      check("k9_pending", exp_q.size(), 0);
      cycles(10);

      // Back-pressure: key 15 released long before the consumer accepts
      ready_mode = 0;
      exp_q.push_back(4'd15);
      keys[15] = 1'b1;
      cycles(70);
      keys[15] = 1'b0;
      cycles(50);
      check("bp_valid", key_valid, 1);
      check("bp_code", key_code, 15);
      check("bp_held", key_held, 1);
      ready_mode = 1;
      wait_held_low(100, ok, n);
      check("bp_release", ok, 1);
      check("bp_pending", exp_q.size(), 0);
      cycles(20);

      // Two rows low in one column is never accepted
      ready_mode = 2;
      multi_key();

      // Reset while a key is waiting for the consumer
      ready_mode = 0;
      keys[6] = 1'b1;
      wait_valid(150, ok);
      check("rst_mid_valid_seen", ok, 1);
      check("rst_mid_code", key_code, 6);
      #2;
      resetn = 1'b0;
      #1;
      check("rst_mid_col_n", col_n, 4'b1110);
      check("rst_mid_code0", key_code, 0);
      check("rst_mid_valid0", key_valid, 0);
      check("rst_mid_held0", key_held, 0);
      keys[6] = 1'b0;
      cycles(3);
      resetn = 1'b1;
      ready_mode = 1;
      @(negedge clk);
      check("rst_mid_rescan_col0", col_n, 4'b1110);
      cycles(60);
      check("rst_mid_no_key", key_valid, 0);
      check("rst_mid_no_held", key_held, 0);

      // Random presses, bounce and multi-key attempts
      ready_mode = 2;
      for (int i = 0; i < 14; i++) begin
         if ($urandom_range(0, 3) == 0) begin
            multi_key();
         end else begin
            press_release($urandom_range(0, 15), 1'($urandom_range(0, 1)));
         end
      end

      check("queue_empty", exp_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/keypad_scan_debounce.md
KEYPAD_SCAN_DEBOUNCE -- requirements
Module: keypad_scan_debounce

Interface
REQ-001 Parameter SCAN_DIV, default 10, clk cycles per column dwell and per debounce sample (1 ms at 10 kHz).
REQ-002 Parameter DEB_COUNT, default 20, consecutive matching samples needed to accept a press or a release.
REQ-003 clk  input  1  single clock for all logic; rising edge.
REQ-004 resetn  input  1  reset, asynchronous assert, active-low.
REQ-005 row_n  input  4  keypad rows, active-low, asynchronous to clk, pulled up externally.
REQ-006 col_n  output  4  column drive, active-low, exactly one bit low at any time.
REQ-007 key_code  output  4  accepted key, code = row*4 + col.
REQ-008 key_valid  output  1  key_code valid; held high until transfer.
REQ-009 key_ready  input  1  consumer accepts; a transfer occurs on any clk edge with key_valid=1 and key_ready=1.
REQ-010 key_held  output  1  high from press acceptance until release is debounced.

Function
REQ-011 row_n SHALL pass through a 2-flop synchronizer (reset value 4'b1111); all decisions use the synchronized value rows_s.
REQ-012 A dwell counter SHALL count 0..SCAN_DIV-1 and wrap; a "sample point" is the cycle with count = SCAN_DIV-1.
REQ-013 States SHALL be SCAN, DEBOUNCE, PRESSED and RELEASE; reset state is SCAN.
REQ-014 SCAN: at each sample point, if rows_s has exactly one bit low, capture row index and current column, clear deb_cnt, go to DEBOUNCE without advancing col; otherwise advance col (3 wraps to 0).
REQ-015 SCAN with rows_s all high or with two or more bits low SHALL be treated as no key (multi-key ignored).
REQ-016 DEBOUNCE: col frozen; at each sample point, if rows_s equals the captured one-low pattern, increment deb_cnt, else clear deb_cnt, advance col and return to SCAN.
REQ-017 DEBOUNCE: when deb_cnt reaches DEB_COUNT, load key_code, set key_valid=1 and key_held=1 on the same edge, and go to PRESSED.
REQ-018 PRESSED: key_valid and key_code SHALL hold stable until a transfer; on the transfer edge key_valid goes 0 and the state goes to RELEASE.
REQ-019 Releasing the key while in PRESSED SHALL NOT drop key_valid; the latched code is delivered.
REQ-020 RELEASE: col frozen; at each sample point, if rows_s = 4'b1111, increment deb_cnt, else clear it; at DEB_COUNT, clear key_held, advance col and go to SCAN.
REQ-021 Entry to RELEASE SHALL clear deb_cnt; the count restarts at zero.
REQ-022 Exactly one transfer per physical press; no auto-repeat.
REQ-023 key_ready while key_valid=0 SHALL have no effect.
REQ-024 deb_cnt width SHALL be clog2(DEB_COUNT+1); it SHALL saturate and never wrap.
REQ-025 col_n SHALL be registered and glitch-free; it changes only on sample-point edges.

Reset
REQ-026 resetn low SHALL immediately force: col_n=4'b1110, key_code=0, key_valid=0, key_held=0, dwell count=0, deb_cnt=0, state=SCAN, synchronizer=4'b1111.
REQ-027 Reset asserted mid-press or mid-handshake SHALL discard the pending key; after deassertion the block rescans from column 0.
REQ-028 Deassertion SHALL be synchronized to clk externally; the block requires no extra cycles before scanning.

Verification (SCAN_DIV=4, DEB_COUNT=3)
REQ-029 Idle: rows_s=1111 for 32 cycles -> col_n cycles 1110,1101,1011,0111,1110 every 4 cycles; key_valid stays 0.
REQ-030 Clean press of row 2, col 1 (row_n=1011 while col_n=1101), key_ready=1 -> key_valid high for exactly 1 cycle with key_code=9; key_held stays 1 until 3 released samples.
REQ-031 Bounce: row low for 1 sample, high for 1, then stable -> no acceptance from the first contact; acceptance after 3 consecutive matching samples; exactly one transfer.
REQ-032 Back-pressure: press key code 0xF with key_ready=0, release, wait 50 cycles, then key_ready=1 -> key_valid held with code 0xF, single transfer, state returns to SCAN.
REQ-033 Two rows low simultaneously in the active column -> no acceptance; scanning continues.
REQ-034 resetn pulsed low while key_valid=1 -> outputs take reset values asynchronously; no key is delivered after release of reset until a new press is accepted.
